ysyx_22050078_wbu: RTL

Write-back unit: the producer side of the register-file write port (i_wen/i_waddr/i_wdata).
- Accepts completed instructions from LSU/EXU over a valid/ready handshake.
- Selects and formats the result (ALU, load with size/sign extension, PC+4, CSR) and buffers it in a 2-entry queue.
- Drives one register write per cycle and keeps a pending-write bitmap that the IDU uses for RAW hazard stalls.

---
 rtl/ysyx_22050078_wbu_pkg.sv | 23 ++
 rtl/ysyx_22050078_wbu_if.sv | 38 +++
 rtl/ysyx_22050078_wbu_ld_ext.sv | 25 ++
 rtl/ysyx_22050078_wbu.sv | 99 +++++++++
 4 files changed

// File: rtl/ysyx_22050078_wbu_pkg.sv
// Shared write-back constants: datapath widths, result-source select and load funct3 codes.
// Also used by the LSU through the load extender.
package ysyx_22050078_wbu_pkg;

    localparam int CPU_WIDTH = 64;
    localparam int REG_ADDRW = 5;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_LOAD = 2'd1,
        WB_SEL_PC4  = 2'd2,
        WB_SEL_CSR  = 2'd3
    } wb_sel_e;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;

endpackage

// File: rtl/ysyx_22050078_wbu_if.sv
// Write-back bundle: upstream result handshake, IDU issue notify, regfile write port and status.
// slave = WBU side, master = the surrounding pipeline / bench.
interface ysyx_22050078_wbu_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic                    i_valid;
    logic                    o_ready;
    logic                    i_rd_wen;
    logic [ADDR_WIDTH-1:0]   i_rd_addr;
    logic [1:0]              i_wb_sel;
    logic [DATA_WIDTH-1:0]   i_alu_res;
    logic [DATA_WIDTH-1:0]   i_mem_rdata;
    logic [2:0]              i_ld_size;
    logic [DATA_WIDTH-1:0]   i_pc;
    logic [DATA_WIDTH-1:0]   i_csr_rdata;
    logic                    i_wb_stall;
    logic                    i_issue_valid;
    logic [ADDR_WIDTH-1:0]   i_issue_rd;
    logic                    o_wen;
    logic [ADDR_WIDTH-1:0]   o_waddr;
    logic [DATA_WIDTH-1:0]   o_wdata;
    logic                    o_commit;
    logic [(1<<ADDR_WIDTH)-1:0] o_pending;
    logic [63:0]             o_retire_cnt;

    modport slave (
        input  i_valid, i_rd_wen, i_rd_addr, i_wb_sel, i_alu_res, i_mem_rdata,
               i_ld_size, i_pc, i_csr_rdata, i_wb_stall, i_issue_valid, i_issue_rd,
        output o_ready, o_wen, o_waddr, o_wdata, o_commit, o_pending, o_retire_cnt
    );

    modport master (
        output i_valid, i_rd_wen, i_rd_addr, i_wb_sel, i_alu_res, i_mem_rdata,
               i_ld_size, i_pc, i_csr_rdata, i_wb_stall, i_issue_valid, i_issue_rd,
        input  o_ready, o_wen, o_waddr, o_wdata, o_commit, o_pending, o_retire_cnt
    );
endinterface

// File: rtl/ysyx_22050078_wbu_ld_ext.sv
// Combinational load formatter: sign/zero extends right-aligned load data by funct3.
// Reserved funct3 111 yields 0.
module ysyx_22050078_ld_ext
    import ysyx_22050078_wbu_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [2:0]            size_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    always_comb begin
        data_o = '0;
        case (size_i)
            LD_LB:   data_o = {{(DATA_WIDTH-8){rdata_i[7]}},   rdata_i[7:0]};
            LD_LH:   data_o = {{(DATA_WIDTH-16){rdata_i[15]}}, rdata_i[15:0]};
            LD_LW:   data_o = {{(DATA_WIDTH-32){rdata_i[31]}}, rdata_i[31:0]};
            LD_LD:   data_o = rdata_i;
            LD_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}},  rdata_i[7:0]};
            LD_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, rdata_i[15:0]};
            LD_LWU:  data_o = {{(DATA_WIDTH-32){1'b0}}, rdata_i[31:0]};
            default: data_o = '0;
        endcase
    end
endmodule

// File: rtl/ysyx_22050078_wbu.sv
// Write-back unit: formats results into a small FIFO, drains one regfile write per cycle,
// and tracks outstanding destination registers for the IDU hazard check.
module ysyx_22050078_wbu
    import ysyx_22050078_wbu_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = CPU_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDRW
) (
    input  logic clk,
    input  logic rst,
    ysyx_22050078_wbu_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0]      wen_q;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NREG-1:0]       pending_q, pending_d, set_vec, clr_vec;
    logic [63:0]           retire_q, retire_d;
    logic [DATA_WIDTH-1:0] ld_data, fmt_data;
    logic                  push, pop, empty;

    ysyx_22050078_ld_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ld_ext (
        .rdata_i (bus.i_mem_rdata),
        .size_i  (bus.i_ld_size),
        .data_o  (ld_data)
    );

    always_comb begin
        fmt_data = bus.i_alu_res;
        case (wb_sel_e'(bus.i_wb_sel))
            WB_SEL_LOAD: fmt_data = ld_data;
            WB_SEL_PC4:  fmt_data = bus.i_pc + DATA_WIDTH'(4);
            WB_SEL_CSR:  fmt_data = bus.i_csr_rdata;
            default:     fmt_data = bus.i_alu_res;
        endcase
    end

    // Ready depends only on registered count, so a same-cycle pop never opens a full queue.
    assign empty       = (cnt_q == '0);
    assign bus.o_ready = (cnt_q < FULL);
    assign push        = bus.i_valid && bus.o_ready;
    assign pop         = !empty && !bus.i_wb_stall;

    assign bus.o_commit = pop;
    assign bus.o_waddr  = empty ? '0 : addr_q[rd_ptr_q];
    assign bus.o_wdata  = empty ? '0 : data_q[rd_ptr_q];
    assign bus.o_wen    = pop && wen_q[rd_ptr_q] && (addr_q[rd_ptr_q] != '0);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        retire_d = pop ? retire_q + 64'd1 : retire_q;
    end

    // Issue-set is applied after write-clear so a re-issued rd stays pending.
    always_comb begin
        set_vec   = (bus.i_issue_valid && bus.i_issue_rd != '0) ? (NREG'(1) << bus.i_issue_rd) : '0;
        clr_vec   = bus.o_wen ? (NREG'(1) << bus.o_waddr) : '0;
        pending_d = ((pending_q & ~clr_vec) | set_vec) & ~NREG'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            retire_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                wen_q[wr_ptr_q]  <= bus.i_rd_wen;
                addr_q[wr_ptr_q] <= bus.i_rd_addr;
                data_q[wr_ptr_q] <= fmt_data;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            retire_q  <= retire_d;
        end
    end

    assign bus.o_pending    = pending_q;
    assign bus.o_retire_cnt = retire_q;

endmodule
